// File: rtl/trace_uart_tx_if.sv
// trace_uart_tx_if: trace field stream from the CPU wrapper plus the UART line and status back.
interface trace_uart_tx_if;
    logic [7:0] data_in;
    logic [2:0] data_type;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;
    logic       overrun;
    modport master (output data_in, data_type, input tx, busy, frames_sent, overrun);
    modport slave  (input data_in, data_type, output tx, busy, frames_sent, overrun);
endinterface

// File: rtl/trace_uart_tx.sv
// trace_uart_tx: reassembles seven trace fields into a sync+checksum 9-byte frame and sends it 8N1.
module trace_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input logic            clk,
    input logic            rst,
    trace_uart_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [7:0]      din_q;
    logic [2:0]      type_q, type_p_q, last_type_q, expect_q;
    logic [6:0][7:0] stage_q, pend_q, stage_d;
    logic [7:0]      pend_ck_q, ck_d;
    logic            pend_valid_q, overrun_q;
    logic [8:0][7:0] frame_q;
    state_t          state_q;
    logic [15:0]     cnt_q;
    logic [3:0]      idx_q;
    logic [2:0]      bit_q;
    logic            tx_q, busy_q;
    logic [7:0]      sent_q;
    logic            accept, store, complete, load, baud_end;

    // A field is taken once its registered tag has been stable for two samples and is new
    always_comb begin
        accept = type_q == type_p_q && type_q != last_type_q;
        store = accept && (type_q == 3'd0 || type_q == expect_q);
        complete = store && type_q == 3'd6;
        stage_d = stage_q;
        if (type_q != 3'd7) stage_d[type_q] = din_q;
        ck_d = stage_d[0] ^ stage_d[1] ^ stage_d[2] ^ stage_d[3] ^ stage_d[4] ^ stage_d[5] ^ stage_d[6];
        load = state_q == IDLE && pend_valid_q;
        baud_end = cnt_q == LAST_CNT;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            din_q <= '0;
            type_q <= 3'd7;
            type_p_q <= 3'd7;
            last_type_q <= 3'd7;
            expect_q <= '0;
            stage_q <= '0;
            pend_q <= '0;
            pend_ck_q <= '0;
            pend_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            din_q <= bus.data_in;
            type_q <= bus.data_type;
            type_p_q <= type_q;
            if (accept) begin
                last_type_q <= type_q;
                expect_q <= complete || !store ? 3'd0 : type_q + 3'd1;
            end
            if (store) stage_q <= stage_d;
            // A load in the same cycle drains the old frame, so the new one is not an overrun
            if (complete) begin
                pend_q <= stage_d;
                pend_ck_q <= ck_d;
                pend_valid_q <= 1'b1;
                overrun_q <= overrun_q | (pend_valid_q & ~load);
            end else if (load) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            bit_q <= '0;
            frame_q <= '0;
            tx_q <= 1'b1;
            busy_q <= 1'b0;
            sent_q <= '0;
        end else begin
            cnt_q <= baud_end || state_q == IDLE ? 16'd0 : cnt_q + 16'd1;
            case (state_q)
                IDLE: if (pend_valid_q) begin
                    frame_q <= {pend_ck_q, pend_q, SYNC_BYTE};
                    idx_q <= '0;
                    tx_q <= 1'b0;
                    busy_q <= 1'b1;
                    state_q <= START;
                end
                START: if (baud_end) begin
                    bit_q <= '0;
                    tx_q <= frame_q[idx_q][0];
                    state_q <= DATA;
                end
                DATA: if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        tx_q <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        tx_q <= frame_q[idx_q][bit_q + 3'd1];
                    end
                end
                STOP: if (baud_end) begin
                    if (idx_q != 4'd8) begin
                        idx_q <= idx_q + 4'd1;
                        tx_q <= 1'b0;
                        state_q <= START;
                    end else begin
                        sent_q <= sent_q + 8'd1;
                        busy_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx = tx_q;
    assign bus.busy = busy_q;
    assign bus.frames_sent = sent_q;
    assign bus.overrun = overrun_q;
endmodule
